shift_pipe: RTL

Parametrised, pipelined barrel shifter for the execute stage. It is the successor to the single-cycle combinational shifter. It adds XLEN generality (32/64), rotate operations, RV64 word-mode (W) operations, a configurable pipeline depth, valid/ready handshaking with backpressure, a pipeline flush and a tag that travels with each operation. It sits between issue and writeback, in parallel with the ALU.

---
 rtl/shift_pipe.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter for the execute stage: SLL/SRL/SRA/ROL/ROR over
// XLEN bits (32 or 64), RV64 word-mode ops, valid/ready handshake with
// backpressure, synchronous flush and a tag that travels with each op.
module shift_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_src,
  input  logic [$clog2(XLEN)-1:0]  in_amt,
  input  logic [2:0]               in_op,
  input  logic                     in_word,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_result,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } op_e;

  // Amount bits handled by stage s: most-significant group in stage 0.
  function automatic int grp_lo(input int s);
    return (SW * (STAGES - 1 - s)) / STAGES;
  endfunction

  function automatic int grp_hi(input int s);
    return (SW * (STAGES - s)) / STAGES - 1;
  endfunction

  // Apply the power-of-two shift steps selected by amount bits lo..hi.
  function automatic logic [XLEN-1:0] part_shift(
    input logic [XLEN-1:0] x,
    input logic [SW-1:0]   amt,
    input logic [2:0]      op,
    input int              lo,
    input int              hi
  );
    logic [XLEN-1:0] r;
    r = x;
    for (int unsigned b = 0; b < SW; b++) begin
      if (int'(b) >= lo && int'(b) <= hi && amt[b]) begin
        case (op)
          OP_SLL:  r = r << (1 << b);
          OP_SRL:  r = r >> (1 << b);
          OP_SRA:  r = $signed(r) >>> (1 << b);
          OP_ROL:  r = (r << (1 << b)) | (r >> (XLEN - (1 << b)));
          OP_ROR:  r = (r >> (1 << b)) | (r << (XLEN - (1 << b)));
          default: r = r;
        endcase
      end
    end
    return r;
  endfunction

  // Per-stage state: stage s holds an operand with groups 0..s-1 applied.
  logic [STAGES-1:0] stg_valid;
  logic [XLEN-1:0]   stg_data [STAGES];
  logic [SW-1:0]     stg_amt  [STAGES];
  logic [2:0]        stg_op   [STAGES];
  logic [STAGES-1:0] stg_word;
  logic [TAG_W-1:0]  stg_tag  [STAGES];
  logic [XLEN-1:0]   stg_next [STAGES];

  logic [STAGES:0]   free;
  logic [STAGES-1:0] move;
  logic [STAGES-1:0] load;
  logic              accept;
  logic              run;

  logic              word_eff;
  logic [SW-1:0]     amt_eff;
  logic [XLEN-1:0]   src_eff;
  logic [XLEN-1:0]   result_fin;

  // Word mode is reduced to a full-width shift: the upper half is pre-filled
  // so that the low 32 bits of the wide result are the 32-bit result
  // (zero fill for SLL/SRL, sign fill for SRA, a copy of the low word for
  // rotates, which makes a wide rotate wrap within 32 bits).
  always_comb begin
    word_eff = (XLEN == 64) && in_word;
    amt_eff  = in_amt;
    src_eff  = in_src;
    if (word_eff) begin
      amt_eff[SW-1] = 1'b0;
      for (int unsigned i = 32; i < XLEN; i++) begin
        case (in_op)
          OP_SRA:         src_eff[i] = in_src[31];
          OP_ROL, OP_ROR: src_eff[i] = in_src[i-32];
          default:        src_eff[i] = 1'b0;
        endcase
      end
    end
  end

  // Partial shift performed by each stage on its registered operand.
  always_comb begin
    for (int unsigned s = 0; s < STAGES; s++) begin
      stg_next[s] = part_shift(stg_data[s], stg_amt[s], stg_op[s],
                               grp_lo(int'(s)), grp_hi(int'(s)));
    end
  end

  // Handshake: a slot is free when empty or when its content moves on;
  // the chain is resolved from the output register backwards.
  always_comb begin
    free[STAGES] = !out_valid || out_ready;
    move         = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      move[STAGES-1-k] = stg_valid[STAGES-1-k] && free[STAGES-k];
      free[STAGES-1-k] = !stg_valid[STAGES-1-k] || free[STAGES-k];
    end
    in_ready = run && free[0];
    accept   = in_valid && in_ready && !flush;
    load     = '0;
    load[0]  = accept;
    for (int unsigned k = 1; k < STAGES; k++) begin
      load[k] = move[k-1];
    end
  end

  // Final formatting: reserved ops yield zero, word results sign-extend bit 31.
  always_comb begin
    result_fin = stg_next[STAGES-1];
    if (stg_op[STAGES-1] > OP_ROR) begin
      result_fin = '0;
    end else if (stg_word[STAGES-1]) begin
      for (int unsigned i = 32; i < XLEN; i++) begin
        result_fin[i] = result_fin[31];
      end
    end
  end

  // Valid bits: flush clears everything and wins over accept/advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      stg_valid <= '0;
      out_valid <= 1'b0;
    end else begin
      run <= 1'b1;
      if (flush) begin
        stg_valid <= '0;
        out_valid <= 1'b0;
      end else begin
        for (int unsigned k = 0; k < STAGES; k++) begin
          if (load[k]) begin
            stg_valid[k] <= 1'b1;
          end else if (move[k]) begin
            stg_valid[k] <= 1'b0;
          end
        end
        if (move[STAGES-1]) begin
          out_valid <= 1'b1;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  // Stage data registers; contents are don't-care while the valid bit is low.
  always_ff @(posedge clk) begin
    if (load[0]) begin
      stg_data[0] <= src_eff;
      stg_amt[0]  <= amt_eff;
      stg_op[0]   <= in_op;
      stg_word[0] <= word_eff;
      stg_tag[0]  <= in_tag;
    end
    for (int unsigned k = 1; k < STAGES; k++) begin
      if (load[k]) begin
        stg_data[k] <= stg_next[k-1];
        stg_amt[k]  <= stg_amt[k-1];
        stg_op[k]   <= stg_op[k-1];
        stg_word[k] <= stg_word[k-1];
        stg_tag[k]  <= stg_tag[k-1];
      end
    end
  end

  // Output register: cleared by reset, held while stalled or flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result <= '0;
      out_tag    <= '0;
    end else if (move[STAGES-1] && !flush) begin
      out_result <= result_fin;
      out_tag    <= stg_tag[STAGES-1];
    end
  end

endmodule
